imem_uart_loader: RTL and testbench

Instruction memory with a built-in UART boot loader; sits directly upstream of the single-cycle MIPS core and drives its `instr` input from the PC value the core exports. After reset it holds the core in reset and receives a program over an 8N1 UART line. It writes the program into the instruction memory, then releases the core. While the core runs, the block is a combinational-read ROM indexed by PC.

---
 rtl/imem_uart_loader.sv | 183 ++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// Instruction memory with a UART boot loader: receives a length-prefixed,
// big-endian program over 8N1 serial, then serves it to the core as a ROM.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              uart_rx,
    input  logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic              cpu_arst_n,
    output logic              load_done,
    output logic              frame_err,
    output logic [ADDR_W:0]   word_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_LEN_HI,
        LD_LEN_LO,
        LD_WORDS,
        LD_RUN,
        LD_ERROR
    } ld_state_t;

    rx_state_t        rx_state, rx_next;
    ld_state_t        ld_state, ld_next;

    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;
    logic             sample_data, byte_valid, stop_bad;

    logic [15:0]      len;
    logic [15:0]      words_rcvd;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_reg;
    logic [ADDR_W:0]  widx;
    logic             mem_we;
    logic             run;

    logic [31:0]      mem [0:DEPTH-1];

    logic             unused_pc;
    assign unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

    // rx_prev is only the edge-detect history of the already synchronised line.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
            RX_START: if (clk_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (clk_cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        sample_data = (rx_state == RX_DATA) && (clk_cnt == BIT_LAST);
        byte_valid  = (rx_state == RX_STOP) && (clk_cnt == BIT_LAST) && rx_sync;
        stop_bad    = (rx_state == RX_STOP) && (clk_cnt == BIT_LAST) && !rx_sync;
    end

    // The bit timer restarts on every state change and after every data sample.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            clk_cnt   <= '0;
            bit_idx   <= '0;
            rx_shift  <= '0;
            frame_err <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || rx_state != rx_next || sample_data)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;

            if (sample_data)
                bit_idx <= bit_idx + 1'b1;
            else if (rx_state != RX_DATA)
                bit_idx <= '0;

            if (sample_data)
                rx_shift <= {rx_sync, rx_shift[7:1]};

            if (stop_bad)
                frame_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) ld_state <= LD_LEN_HI;
        else         ld_state <= ld_next;
    end

    // A frame error aborts any load in progress, but a running core is left alone.
    always_comb begin
        ld_next = ld_state;
        case (ld_state)
            LD_LEN_HI: if (byte_valid) ld_next = LD_LEN_LO;
            LD_LEN_LO: if (byte_valid)
                           ld_next = ({len[15:8], rx_shift} == 16'd0) ? LD_RUN : LD_WORDS;
            LD_WORDS:  if (byte_valid && byte_idx == 2'd3 && words_rcvd == len - 16'd1)
                           ld_next = LD_RUN;
            LD_RUN:    ld_next = LD_RUN;
            LD_ERROR:  ld_next = LD_ERROR;
            default:   ld_next = LD_ERROR;
        endcase
        if (frame_err && ld_state != LD_RUN)
            ld_next = LD_ERROR;
    end

    always_comb begin
        run        = (ld_state == LD_RUN);
        load_done  = run;
        cpu_arst_n = run;
        word_count = run ? widx : '0;
        instr      = run ? mem[pc[ADDR_W+1:2]] : 32'h0;
        mem_we     = (ld_state == LD_WORDS) && byte_valid && (byte_idx == 2'd3) && !widx[ADDR_W];
    end

    // widx saturates at the depth so surplus words are consumed but never written.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            len        <= '0;
            words_rcvd <= '0;
            byte_idx   <= '0;
            asm_reg    <= '0;
            widx       <= '0;
        end else if (byte_valid) begin
            case (ld_state)
                LD_LEN_HI: len[15:8] <= rx_shift;
                LD_LEN_LO: len[7:0]  <= rx_shift;
                LD_WORDS: begin
                    byte_idx <= byte_idx + 1'b1;
                    asm_reg  <= {asm_reg[15:0], rx_shift};
                    if (byte_idx == 2'd3) begin
                        words_rcvd <= words_rcvd + 16'd1;
                        if (!widx[ADDR_W])
                            widx <= widx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[widx[ADDR_W-1:0]] <= {asm_reg, rx_shift};
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: two instances (256-word and 4-word)
// share the serial line, reset and pc.
module tb_imem_uart_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        uart_rx;
    logic [31:0] pc;

    logic [31:0] instr, instr_s;
    logic        cpu_arst_n, cpu_arst_n_s;
    logic        load_done, load_done_s;
    logic        frame_err, frame_err_s;
    logic [8:0]  word_count;
    logic [2:0]  word_count_s;

    int checks = 0;
    int errors = 0;

    logic watch_abort = 1'b0;
    logic abort_rise  = 1'b0;

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
        .clk(clk), .arst_n(arst_n), .uart_rx(uart_rx), .pc(pc),
        .instr(instr), .cpu_arst_n(cpu_arst_n), .load_done(load_done),
        .frame_err(frame_err), .word_count(word_count)
    );

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) dut_small (
        .clk(clk), .arst_n(arst_n), .uart_rx(uart_rx), .pc(pc),
        .instr(instr_s), .cpu_arst_n(cpu_arst_n_s), .load_done(load_done_s),
        .frame_err(frame_err_s), .word_count(word_count_s)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (watch_abort && cpu_arst_n !== 1'b0)
            abort_rise = 1'b1;
    end

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_data_bits(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_data_bits(d);
        send_bit(1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic do_reset;
        uart_rx = 1'b1;
        arst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        pc = 32'h0;
        uart_rx = 1'b1;
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checks++; if (cpu_arst_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_arst_n: got %b want 0", cpu_arst_n); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_done: got %b want 0", load_done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("[TB] FAIL reset_word_count: got %0d want 0", word_count); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 00000000", instr); end
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic_load;
        do_reset();
        pc = 32'h0;
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h20080005);
        send_byte(8'h20);
        send_byte(8'h09);
        send_byte(8'h00);
        send_data_bits(8'h0A);
        uart_rx = 1'b1;
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_before_stop: got %b want 0", load_done); end
        checks++; if (cpu_arst_n !== 1'b0) begin errors++; $display("[TB] FAIL basic_cpu_before_stop: got %b want 0", cpu_arst_n); end
        repeat (CPB) @(posedge clk);
        #1;
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL basic_load_done: got %b want 1", load_done); end
        checks++; if (cpu_arst_n !== 1'b1) begin errors++; $display("[TB] FAIL basic_cpu_arst_n: got %b want 1", cpu_arst_n); end
        checks++; if (word_count !== 9'd2) begin errors++; $display("[TB] FAIL basic_word_count: got %0d want 2", word_count); end
        pc = 32'h0; #1;
        checks++; if (instr !== 32'h20080005) begin errors++; $display("[TB] FAIL basic_pc0: got %h want 20080005", instr); end
        pc = 32'h4; #1;
        checks++; if (instr !== 32'h2009000A) begin errors++; $display("[TB] FAIL basic_pc4: got %h want 2009000a", instr); end
        pc = 32'h6; #1;
        checks++; if (instr !== 32'h2009000A) begin errors++; $display("[TB] FAIL basic_pc6_lowbits: got %h want 2009000a", instr); end
    endtask

    task automatic test_zero_count;
        do_reset();
        pc = 32'h0; #1;
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL zero_instr_before_run: got %h want 00000000", instr); end
        send_byte(8'h00);
        send_byte(8'h00);
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL zero_load_done: got %b want 1", load_done); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("[TB] FAIL zero_word_count: got %0d want 0", word_count); end
        checks++; if (instr !== 32'h20080005) begin errors++; $display("[TB] FAIL zero_mem_kept: got %h want 20080005", instr); end
        send_word(32'h12345678);
        checks++; if (instr !== 32'h20080005) begin errors++; $display("[TB] FAIL zero_rx_ignored: got %h want 20080005", instr); end
        checks++; if (word_count !== 9'd0) begin errors++; $display("[TB] FAIL zero_word_count_after: got %0d want 0", word_count); end
    endtask

    task automatic test_frame_error;
        do_reset();
        pc = 32'h0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_data_bits(8'hBB);
        send_bit(1'b0);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_flag: got %b want 1", frame_err); end
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL ferr_load_done: got %b want 0", load_done); end
        checks++; if (cpu_arst_n !== 1'b0) begin errors++; $display("[TB] FAIL ferr_cpu_arst_n: got %b want 0", cpu_arst_n); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL ferr_instr: got %h want 00000000", instr); end
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'hEE);
        checks++; if (load_done !== 1'b0) begin errors++; $display("[TB] FAIL ferr_stays_stuck: got %b want 0", load_done); end
        do_reset();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_cleared: got %b want 0", frame_err); end
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hCAFEF00D);
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL ferr_reload_done: got %b want 1", load_done); end
        checks++; if (instr !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL ferr_reload_pc0: got %h want cafef00d", instr); end
    endtask

    task automatic test_glitch;
        do_reset();
        pc = 32'h0;
        uart_rx = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h01020304);
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL glitch_load_done: got %b want 1", load_done); end
        checks++; if (word_count !== 9'd1) begin errors++; $display("[TB] FAIL glitch_word_count: got %0d want 1", word_count); end
        checks++; if (instr !== 32'h01020304) begin errors++; $display("[TB] FAIL glitch_pc0: got %h want 01020304", instr); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL glitch_frame_err: got %b want 0", frame_err); end
    endtask

    task automatic test_addr_wrap;
        do_reset();
        send_byte(8'h00);
        send_byte(8'h05);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        send_word(32'h55555555);
        checks++; if (load_done_s !== 1'b1) begin errors++; $display("[TB] FAIL wrap_small_done: got %b want 1", load_done_s); end
        checks++; if (word_count_s !== 3'd4) begin errors++; $display("[TB] FAIL wrap_small_word_count: got %0d want 4", word_count_s); end
        checks++; if (word_count !== 9'd5) begin errors++; $display("[TB] FAIL wrap_big_word_count: got %0d want 5", word_count); end
        pc = 32'h0; #1;
        checks++; if (instr_s !== 32'h11111111) begin errors++; $display("[TB] FAIL wrap_small_pc0: got %h want 11111111", instr_s); end
        pc = 32'hC; #1;
        checks++; if (instr_s !== 32'h44444444) begin errors++; $display("[TB] FAIL wrap_small_pc12: got %h want 44444444", instr_s); end
        pc = 32'h10; #1;
        checks++; if (instr_s !== 32'h11111111) begin errors++; $display("[TB] FAIL wrap_small_pc16: got %h want 11111111", instr_s); end
        checks++; if (instr !== 32'h55555555) begin errors++; $display("[TB] FAIL wrap_big_pc16: got %h want 55555555", instr); end
    endtask

    task automatic test_abort;
        do_reset();
        pc = 32'h0;
        abort_rise  = 1'b0;
        watch_abort = 1'b1;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        send_data_bits(8'hEF);
        watch_abort = 1'b0;
        checks++; if (abort_rise !== 1'b0) begin errors++; $display("[TB] FAIL abort_cpu_held: got rise=%b want 0", abort_rise); end
        send_bit(1'b1);
        checks++; if (load_done !== 1'b1) begin errors++; $display("[TB] FAIL abort_reload_done: got %b want 1", load_done); end
        checks++; if (word_count !== 9'd1) begin errors++; $display("[TB] FAIL abort_word_count: got %0d want 1", word_count); end
        checks++; if (instr !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL abort_pc0: got %h want deadbeef", instr); end
    endtask

    initial begin
        arst_n  = 1'b1;
        uart_rx = 1'b1;
        pc      = 32'h0;
        test_reset();
        test_basic_load();
        test_zero_count();
        test_frame_error();
        test_glitch();
        test_addr_wrap();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
